// File: rtl/coax_pkg.sv
// coax_pkg: definitions shared by the coax TX loader and its FIFO.
//   CMD_TX / CMD_RX  - SPI command bytes that open a TX or RX transaction
//   WORD_WIDTH       - width of one coax word
//   tx_loader_state_t - loader FSM states
package coax_pkg;

    localparam logic [7:0] CMD_TX     = 8'h04;
    localparam logic [7:0] CMD_RX     = 8'h05;
    localparam int         WORD_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        SKIP
    } tx_loader_state_t;

endpackage

// File: rtl/coax_tx_fifo.sv
// coax_tx_fifo: first-word fall-through FIFO with registered full/empty.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   push, push_data - write strobe and word (ignored while full)
//   pop             - read strobe (ignored while empty)
//   data            - head-of-FIFO word
//   empty, full     - registered status flags
module coax_tx_fifo
    import coax_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WORD_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           wr_next;
    logic [AW:0]           rd_next;
    logic                  do_push;
    logic                  do_pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_next = do_push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_next = do_pop  ? rd_ptr + PTR_ONE : rd_ptr;

    assign data = mem[rd_ptr[AW-1:0]];

    // Storage is reset so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= (wr_next == rd_next);
            full   <= (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/coax_tx_loader.sv
// coax_tx_loader: decodes the SPI byte stream, assembles TX byte pairs into
// 10-bit coax words and buffers them for the coax transmitter.
// Ports:
//   clk, reset                   - clock, asynchronous active-low reset
//   spi_cs                       - active-low chip select (clk-synchronous)
//   spi_rx_data, spi_rx_strobe   - received byte and its one-cycle strobe
//   tx_data, tx_empty, tx_read   - FWFT drain port for the transmitter
//   tx_full                      - FIFO holds DEPTH words
//   tx_overflow                  - sticky, a word was dropped on full
//   tx_framing_error             - sticky, only with COAX_TX_STRICT_EN
//   tx_busy                      - TX transaction open (HIGH/LOW)
// Build option COAX_TX_STRICT_EN: a high byte with bits [7:2] set aborts
// the transaction into SKIP and raises tx_framing_error.
//
// state | meaning
// IDLE  | waiting for a command byte
// HIGH  | TX open, expecting the high byte
// LOW   | high byte held, expecting the low byte
// SKIP  | non-TX command, ignore bytes until cs rises
module coax_tx_loader
    import coax_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic [7:0]            spi_rx_data,
    input  logic                  spi_rx_strobe,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_empty,
    input  logic                  tx_read,
    output logic                  tx_full,
    output logic                  tx_overflow,
`ifdef COAX_TX_STRICT_EN
    output logic                  tx_framing_error,
`endif
    output logic                  tx_busy
);

    tx_loader_state_t      state;
    logic [1:0]            high_q;
    logic                  push;
    logic [WORD_WIDTH-1:0] word;

    // Word is written straight from the low-byte strobe so it lands on the
    // edge that samples that strobe.
    assign push = (state == LOW) && spi_rx_strobe && !spi_cs;
    assign word = {high_q, spi_rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            high_q      <= '0;
            tx_busy     <= 1'b0;
            tx_overflow <= 1'b0;
`ifdef COAX_TX_STRICT_EN
            tx_framing_error <= 1'b0;
`endif
        end else if (spi_cs) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
        end else begin
            if (push && tx_full) begin
                tx_overflow <= 1'b1;
            end
            if (spi_rx_strobe) begin
                case (state)
                    IDLE: begin
                        if (spi_rx_data == CMD_TX) begin
                            state       <= HIGH;
                            tx_busy     <= 1'b1;
                            tx_overflow <= 1'b0;
`ifdef COAX_TX_STRICT_EN
                            tx_framing_error <= 1'b0;
`endif
                        end else begin
                            state <= SKIP;
                        end
                    end
                    HIGH: begin
`ifdef COAX_TX_STRICT_EN
                        if (|spi_rx_data[7:2]) begin
                            state            <= SKIP;
                            tx_busy          <= 1'b0;
                            tx_framing_error <= 1'b1;
                        end else begin
                            high_q <= spi_rx_data[1:0];
                            state  <= LOW;
                        end
`else
                        high_q <= spi_rx_data[1:0];
                        state  <= LOW;
`endif
                    end
                    LOW:     state <= HIGH;
                    default: state <= SKIP;
                endcase
            end
        end
    end

    coax_tx_fifo #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (tx_read),
        .data      (tx_data),
        .empty     (tx_empty),
        .full      (tx_full)
    );

endmodule

// File: tb/tb_coax_tx_loader.sv
// tb_coax_tx_loader: directed stimulus for coax_tx_loader with a scoreboard
// queue of expected words drained by an independent monitor process.
module tb_coax_tx_loader;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic       tx_read;
    logic [9:0] tx_data;
    logic       tx_empty;
    logic       tx_full;
    logic       tx_overflow;
    logic       tx_busy;
`ifdef COAX_TX_STRICT_EN
    logic       tx_framing_error;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [9:0] expq[$];
    bit         drain_en = 1'b0;

    always #5 clk = ~clk;

    coax_tx_loader #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cs           (spi_cs),
        .spi_rx_data      (spi_rx_data),
        .spi_rx_strobe    (spi_rx_strobe),
        .tx_data          (tx_data),
        .tx_empty         (tx_empty),
        .tx_read          (tx_read),
        .tx_full          (tx_full),
        .tx_overflow      (tx_overflow),
`ifdef COAX_TX_STRICT_EN
        .tx_framing_error (tx_framing_error),
`endif
        .tx_busy          (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops whenever draining is enabled and a word is presented.
    initial begin
        tx_read = 1'b0;
        forever begin
            @(negedge clk);
            if (drain_en && tx_empty === 1'b0) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", tx_data);
                end else begin
                    check("word", {22'd0, tx_data}, {22'd0, expq.pop_front()});
                end
                tx_read = 1'b1;
            end else begin
                tx_read = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
    endtask

    task automatic send_pair(input logic [9:0] w);
        expq.push_back(w);
        send_byte({6'd0, w[9:8]});
        send_byte(w[7:0]);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        @(negedge clk);
        check("busy_after_cs", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        drain_en = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'd0, (expq.size() != 0)}, 32'd0);
        repeat (2) @(negedge clk);
        check("empty_after_drain", {31'd0, tx_empty}, 32'd1);
    endtask

    initial begin
        logic [9:0] w;
        reset         = 1'b0;
        spi_cs        = 1'b1;
        spi_rx_data   = 8'h00;
        spi_rx_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",     {22'd0, tx_data},     32'd0);
        check("rst_empty",    {31'd0, tx_empty},    32'd1);
        check("rst_full",     {31'd0, tx_full},     32'd0);
        check("rst_overflow", {31'd0, tx_overflow}, 32'd0);
        check("rst_busy",     {31'd0, tx_busy},     32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single word with latency check
        cs_low();
        send_byte(8'h04);
        check("busy_rise", {31'd0, tx_busy}, 32'd1);
        send_byte(8'h03);
        send_byte(8'hFF);
        check("one_empty", {31'd0, tx_empty}, 32'd0);
        check("one_data",  {22'd0, tx_data},  32'h3FF);
        expq.push_back(10'h3FF);
        wait_drain();
        cs_high();

        // back-to-back multi-word ordering
        cs_low();
        send_byte(8'h04);
        send_pair(10'h123);
        send_pair(10'h245);
        wait_drain();
        cs_high();

        // overflow: DEPTH+1 pairs without draining
        drain_en = 1'b0;
        cs_low();
        send_byte(8'h04);
        for (int i = 0; i <= DEPTH; i++) begin
            w = 10'(i * 37 + 5);
            if (i < DEPTH) expq.push_back(w);
            send_byte({6'd0, w[9:8]});
            send_byte(w[7:0]);
        end
        check("ovf_full",  {31'd0, tx_full},     32'd1);
        check("ovf_flag",  {31'd0, tx_overflow}, 32'd1);
        check("ovf_busy",  {31'd0, tx_busy},     32'd1);
        cs_high();
        check("ovf_sticky", {31'd0, tx_overflow}, 32'd1);
        cs_low();
        send_byte(8'h04);
        check("ovf_clear", {31'd0, tx_overflow}, 32'd0);
        cs_high();
        wait_drain();
        check("ovf_full_after", {31'd0, tx_full}, 32'd0);

        // non-TX command
        cs_low();
        send_byte(8'h05);
        check("rx_busy0", {31'd0, tx_busy}, 32'd0);
        send_byte(8'h00);
        check("rx_busy1", {31'd0, tx_busy}, 32'd0);
        send_byte(8'h00);
        check("rx_busy2", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("rx_empty", {31'd0, tx_empty}, 32'd1);
        cs_high();

        // abort with a latched high byte, then a clean transaction
        cs_low();
        send_byte(8'h04);
        send_byte(8'h02);
        cs_high();
        cs_low();
        send_byte(8'h04);
        send_pair(10'h011);
        wait_drain();
        cs_high();

        // strobe in the same cycle cs rises is ignored
        cs_low();
        send_byte(8'h04);
        send_byte(8'h01);
        spi_cs        = 1'b1;
        spi_rx_data   = 8'h55;
        spi_rx_strobe = 1'b1;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
        repeat (2) @(negedge clk);
        check("cs_edge_empty", {31'd0, tx_empty}, 32'd1);

        // reset mid-transaction discards buffered words
        drain_en = 1'b0;
        cs_low();
        send_byte(8'h04);
        send_pair(10'h2AA);
        send_pair(10'h155);
        check("pre_rst_empty", {31'd0, tx_empty}, 32'd0);
        expq.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_empty", {31'd0, tx_empty}, 32'd1);
        check("mid_rst_data",  {22'd0, tx_data},  32'd0);
        check("mid_rst_busy",  {31'd0, tx_busy},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        cs_high();
        cs_low();
        send_byte(8'h04);
        send_pair(10'h3C3);
        wait_drain();
        cs_high();

`ifdef COAX_TX_STRICT_EN
        cs_low();
        send_byte(8'h04);
        send_byte(8'h84);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        check("strict_fe",    {31'd0, tx_framing_error}, 32'd1);
        check("strict_empty", {31'd0, tx_empty},         32'd1);
        check("strict_busy",  {31'd0, tx_busy},          32'd0);
        cs_high();
        cs_low();
        send_byte(8'h04);
        check("strict_fe_clear", {31'd0, tx_framing_error}, 32'd0);
        cs_high();
`endif

        check("queue_left", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
